// File: rtl/lap_core_seq_if.sv
// Host-queue and issue handshake bundle for the LAP core sequencer.
// The master side is the host plus vinst_ctl. The slave side is the sequencer.
interface lap_core_seq_if #(
    parameter int INST_W = 148
);
    logic              host_valid;
    logic              host_ready;
    logic [INST_W-1:0] host_inst;
    logic              iavail;
    logic [INST_W-1:0] inst;
    logic              ird;

    modport master (
        output host_valid, host_inst, ird,
        input  host_ready, iavail, inst
    );

    modport slave (
        input  host_valid, host_inst, ird,
        output host_ready, iavail, inst
    );
endinterface

// File: rtl/lap_core_seq.sv
// Core-level instruction sequencer for the LAP systolic array.
// It queues host instructions, issues them to vinst_ctl, tracks retires and skews the channel addresses.
module lap_core_seq #(
    parameter int N       = 4,
    parameter int INST_W  = 148,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    lap_core_seq_if.slave            bus,
    input  logic                     start,
    input  logic [CNT_W-1:0]         expect_cnt,
    input  logic                     done_in,
    input  logic [ADDR_W-1:0]        a0,
    output logic [N*ADDR_W-1:0]      a_sk,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic [CNT_W-1:0]         issued,
    output logic [CNT_W-1:0]         retired,
    output logic                     busy,
    output logic                     passed,
    output logic                     failed
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int FCN_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    logic [INST_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCN_W-1:0]  cnt_q;
    logic              push;
    logic              pop;

    assign bus.host_ready = (cnt_q != FCN_W'(DEPTH));
    assign push           = bus.host_valid && bus.host_ready;
    assign pop            = bus.iavail && bus.ird;
    assign bus.inst       = (cnt_q != '0) ? mem[rd_ptr] : '0;
    assign fifo_cnt       = cnt_q;

    // The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + FCN_W'(1);
                2'b01:   cnt_q <= cnt_q - FCN_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: storage is not reset. An empty queue masks inst to zero,
    // so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (reset && push) mem[wr_ptr] <= bus.host_inst;
    end

    // ------------------------------------------------------------------
    // Run control FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  expect_q, expect_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              passed_q, passed_d;
    logic              failed_q, failed_d;
    logic              spurious;
    logic              retire;

    assign bus.iavail = (state_q == S_RUN) && (cnt_q != '0) && (issued_q != expect_q);
    assign spurious   = done_in && (retired_q == issued_q);
    assign retire     = done_in && !spurious;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            expect_q  <= '0;
            issued_q  <= '0;
            retired_q <= '0;
            wd_q      <= '0;
            passed_q  <= 1'b0;
            failed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            expect_q  <= expect_d;
            issued_q  <= issued_d;
            retired_q <= retired_d;
            wd_q      <= wd_d;
            passed_q  <= passed_d;
            failed_q  <= failed_d;
        end
    end

    // NOTE: every next-state value gets a default before the case.
    // Without the default, a path that skips an assignment would infer a latch.
    always_comb begin
        state_d   = state_q;
        expect_d  = expect_q;
        issued_d  = issued_q;
        retired_d = retired_q;
        wd_d      = wd_q;
        passed_d  = passed_q;
        failed_d  = failed_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    expect_d  = expect_cnt;
                    issued_d  = '0;
                    retired_d = '0;
                    wd_d      = '0;
                    failed_d  = 1'b0;
                    if (expect_cnt == '0) begin
                        state_d  = S_DONE;
                        passed_d = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        passed_d = 1'b0;
                    end
                end
            end
            S_RUN, S_DRAIN: begin
                if (pop)    issued_d  = issued_q + CNT_W'(1);
                if (retire) retired_d = retired_q + CNT_W'(1);
                wd_d = (pop || retire) ? '0 : wd_q + WD_W'(1);

                if (state_q == S_RUN && issued_d == expect_q) state_d = S_DRAIN;

                // A retire with nothing outstanding is an error and is not counted.
                if (spurious) begin
                    state_d  = S_DONE;
                    failed_d = 1'b1;
                end else if (retire && retired_d == expect_q) begin
                    state_d  = S_DONE;
                    passed_d = 1'b1;
                end else if (!(pop || retire) && wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d  = S_DONE;
                    failed_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign issued  = issued_q;
    assign retired = retired_q;
    assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign passed  = passed_q;
    assign failed  = failed_q;

    // ------------------------------------------------------------------
    // Diagonal address skew: channel i sees a0 delayed by i cycles
    // ------------------------------------------------------------------
    assign a_sk[ADDR_W-1:0] = a0;

    if (N > 1) begin : g_skew
        logic [ADDR_W-1:0] sk_q [1:N-1];

        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int i = 1; i < N; i++) sk_q[i] <= '0;
            end else begin
                sk_q[1] <= a0;
                for (int i = 2; i < N; i++) sk_q[i] <= sk_q[i-1];
            end
        end

        for (genvar g = 1; g < N; g++) begin : g_out
            assign a_sk[g*ADDR_W +: ADDR_W] = sk_q[g];
        end
    end
endmodule
